booth_mult_unit: RTL and testbench

- Iterative signed radix-4 Booth multiplier feeding the processor's 66-bit product register; sits in the multdiv path beside the ALU.
- Accepts a start pulse with two 32-bit operands and retires one Booth digit per cycle over 16 cycles.
- Presents the low 32 bits of the product with an overflow flag and a one-cycle ready strobe to the pipeline stall/writeback logic.

---
 rtl/booth_mult_unit_pkg.sv | 52 +++++
 rtl/booth_mult_unit_recode.sv | 47 ++++
 rtl/booth_mult_unit_reg.sv | 34 +++
 rtl/booth_mult_unit.sv | 152 +++++++++++++++
 tb/tb_booth_mult_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/booth_mult_unit_pkg.sv
// ============================================================================
//  Module      : booth_mult_unit_pkg
//  Description : Shared widths, FSM state encoding and Booth digit select
//                encoding for the radix-4 Booth multiplier.
//                Contents:
//                  MULT_WIDTH / MULT_ITER / PROD_WIDTH - datapath sizes
//                  mult_state_e                        - control FSM states
//                  booth_sel_e                         - Booth digit selects
//                  booth_decode()                      - 3-bit window -> select
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_mult_unit_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITER  = MULT_WIDTH / 2;
    localparam int PROD_WIDTH = 2 * MULT_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_PM   = 3'd1,
        SEL_P2M  = 3'd2,
        SEL_NM   = 3'd3,
        SEL_N2M  = 3'd4
    } booth_sel_e;

    // Window is {P[1], P[0], q_prev}: the two multiplier bits being retired
    // plus the bit shifted out on the previous step.
    function automatic booth_sel_e booth_decode(input logic [2:0] window);
        booth_sel_e sel;
        case (window)
            3'b001,
            3'b010:  sel = SEL_PM;
            3'b011:  sel = SEL_P2M;
            3'b100:  sel = SEL_N2M;
            3'b101,
            3'b110:  sel = SEL_NM;
            default: sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_mult_unit_recode.sv
// ============================================================================
//  Module      : booth_recode
//  Description : Combinational radix-4 Booth recoder. Turns the 3-bit
//                multiplier window into a digit select and the matching
//                sign-extended addend (0, +M, +2M, -M, -2M).
//  Ports       : bits_i   [2:0]       {P[1], P[0], q_prev}
//                m_i      [WIDTH-1:0] multiplicand, two's complement
//                sel_o                 decoded Booth digit
//                addend_o [WIDTH+1:0]  selected addend, sign-extended
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_recode
    import booth_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [2:0]       bits_i,
    input  logic [WIDTH-1:0] m_i,
    output booth_sel_e       sel_o,
    output logic [WIDTH+1:0] addend_o
);

    // Two guard bits keep +/-2M representable: |2*(-2^(W-1))| = 2^W fits
    // in a signed (W+2)-bit value.
    logic [WIDTH+1:0] w_m1;
    logic [WIDTH+1:0] w_m2;

    assign w_m1 = {{2{m_i[WIDTH-1]}}, m_i};
    assign w_m2 = {m_i[WIDTH-1], m_i, 1'b0};

    always_comb begin
        sel_o    = booth_decode(bits_i);
        addend_o = '0;
        case (sel_o)
            SEL_PM:  addend_o = w_m1;
            SEL_P2M: addend_o = w_m2;
            SEL_NM:  addend_o = -w_m1;
            SEL_N2M: addend_o = -w_m2;
            default: addend_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/booth_mult_unit_reg.sv
// ============================================================================
//  Module      : booth_mult_unit_reg
//  Description : Generic enable/clear register used as the multiplier
//                product register. Clear is asynchronous and active-high.
//  Ports       : clk_i            rising-edge clock
//                clr_i            asynchronous clear, active-high
//                en_i             load enable
//                d_i  [WIDTH-1:0] next value
//                q_o  [WIDTH-1:0] registered value
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult_unit_reg #(
    parameter int WIDTH = 66
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/booth_mult_unit.sv
// ============================================================================
//  Module      : booth_mult_unit
//  Description : Iterative signed radix-4 Booth multiplier. One Booth digit
//                is retired per clock; the low WIDTH bits of the product and
//                a signed overflow flag are presented with a one-cycle ready
//                strobe.
//  Ports       : clk            rising-edge clock
//                reset          asynchronous reset, active-low
//                ctrl_MULT      start pulse (restarts any op in flight)
//                data_operandA  multiplicand, two's complement
//                data_operandB  multiplier, two's complement
//                data_result    product[WIDTH-1:0]
//                data_exception product does not fit in signed WIDTH bits
//                data_resultRDY one-cycle result-valid strobe
//                busy           high while Booth digits are being retired
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult_unit
    import booth_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int ITER = WIDTH / 2;
    localparam int PW   = 2 * WIDTH + 2;
    localparam int AW   = WIDTH + 2;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER);

    mult_state_e      state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             qprev_q, qprev_d;

    logic [PW-1:0]    prod_q;
    logic [PW-1:0]    prod_d;
    logic             prod_en;

    logic             iterating;
    booth_sel_e       booth_sel;
    logic [AW-1:0]    addend;
    logic [AW-1:0]    acc_cur;
    logic [AW-1:0]    acc_new;
    logic [PW-1:0]    prod_shifted;
    logic [WIDTH:0]   upper_bits;

    // ------------------------------------------------------------------
    // Booth datapath: add the selected multiple to the accumulator half of
    // P, then arithmetic-shift the whole {acc, mplier} pair right by two.
    // ------------------------------------------------------------------
    booth_recode #(
        .WIDTH    (WIDTH)
    ) u_recode (
        .bits_i   ({prod_q[1:0], qprev_q}),
        .m_i      (m_q),
        .sel_o    (booth_sel),
        .addend_o (addend)
    );

    assign acc_cur      = prod_q[PW-1:WIDTH];
    assign acc_new      = (booth_sel == SEL_ZERO) ? acc_cur : (acc_cur + addend);
    assign prod_shifted = {{2{acc_new[AW-1]}}, acc_new, prod_q[WIDTH-1:2]};

    // Count reaches ITER one cycle after the last digit is retired; that
    // settle cycle is the only BUSY cycle with busy low and no update.
    assign iterating = (state_q == ST_BUSY) && (count_q != LAST);

    // A start always wins: it reloads P even mid-operation.
    assign prod_en = ctrl_MULT | iterating;
    assign prod_d  = ctrl_MULT ? {{AW{1'b0}}, data_operandB} : prod_shifted;

    booth_mult_unit_reg #(
        .WIDTH (PW)
    ) u_prod_reg (
        .clk_i (clk),
        .clr_i (~reset),
        .en_i  (prod_en),
        .d_i   (prod_d),
        .q_o   (prod_q)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            m_q     <= '0;
            qprev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            m_q     <= m_d;
            qprev_q <= qprev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        m_d     = m_q;
        qprev_d = qprev_q;

        if (ctrl_MULT) begin
            // Load happens on the same edge that samples the start pulse;
            // an op in flight is dropped without a strobe.
            state_d = ST_BUSY;
            count_d = '0;
            m_d     = data_operandA;
            qprev_d = 1'b0;
        end else begin
            case (state_q)
                ST_BUSY: begin
                    if (count_q == LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                        qprev_d = prod_q[1];
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. P only changes on load/iterate, so the result and overflow
    // flag hold after the strobe until the next start.
    // ------------------------------------------------------------------
    assign upper_bits     = prod_q[2*WIDTH-1:WIDTH-1];
    assign data_result    = prod_q[WIDTH-1:0];
    assign data_exception = ~((&upper_bits) | ~(|upper_bits));
    assign data_resultRDY = (state_q == ST_DONE);
    assign busy           = iterating;

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_unit.sv
// ============================================================================
//  Module      : tb_booth_mult_unit
//  Description : Self-checking bench for booth_mult_unit. Expected results
//                come from a signed 64-bit reference multiply queued at
//                start and compared when the ready strobe appears.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_mult_unit;

    logic        clk;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    booth_mult_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p;
        logic [63:0] pv;
        p     = longint'($signed(a)) * longint'($signed(b));
        pv    = p;
        e.res = pv[31:0];
        e.exc = !((pv[63:31] == 33'd0) || (&pv[63:31]));
        return e;
    endfunction

    // Drive a start pulse so it is sampled on the next rising edge (E0).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1 ctrl_MULT = 1'b0;
    endtask

    // Returns the number of rising edges after E0 until ready is seen
    // (-1 on timeout) and the number of sampled cycles with busy high.
    task automatic wait_rdy(input bit scramble, output int edges, output int busy_cycles);
        int n;
        n           = 0;
        busy_cycles = 0;
        edges       = -1;
        while (n < 40) begin
            @(negedge clk);
            if (data_resultRDY === 1'b1) begin
                edges = n;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            if (scramble) begin
                data_operandA = $urandom;
                data_operandB = $urandom;
            end
            n++;
        end
    endtask

    task automatic test_reset;
        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #2;
        vectors++; if (data_result !== 32'd0) begin miscompares++; $display("FAIL reset_result got %h want %h", data_result, 32'd0); end
        vectors++; if (data_exception !== 1'b0) begin miscompares++; $display("FAIL reset_exc got %b want 0", data_exception); end
        vectors++; if (data_resultRDY !== 1'b0) begin miscompares++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int   n, bc;
        exp_t e;
        start_op(32'd3, 32'd5);
        wait_rdy(1'b0, n, bc);
        vectors++; if (n !== 17) begin miscompares++; $display("FAIL basic_latency got %0d want 17", n); end
        vectors++; if (bc !== 16) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 16", bc); end
        e = sb.pop_front();
        vectors++; if (data_result !== e.res || e.res !== 32'h0000000F) begin miscompares++; $display("FAIL basic_result got %h want %h", data_result, 32'h0000000F); end
        vectors++; if (data_exception !== 1'b0) begin miscompares++; $display("FAIL basic_exc got %b want 0", data_exception); end
        @(negedge clk);
        vectors++; if (data_resultRDY !== 1'b0) begin miscompares++; $display("FAIL basic_strobe_width got %b want 0", data_resultRDY); end
        repeat (3) @(negedge clk);
        vectors++; if (data_result !== 32'h0000000F) begin miscompares++; $display("FAIL basic_hold got %h want %h", data_result, 32'h0000000F); end
    endtask

    task automatic test_signed;
        logic [31:0] av[8];
        logic [31:0] bv[8];
        int          n, bc;
        exp_t        e;
        av = '{32'hFFFFFFF9, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, $urandom, $urandom};
        bv = '{32'h00000006, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h12345678, 32'hFFFFFFFF, $urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            start_op(av[i], bv[i]);
            wait_rdy(1'b0, n, bc);
            e = sb.pop_front();
            vectors++; if (n !== 17) begin miscompares++; $display("FAIL signed_latency[%0d] got %0d want 17", i, n); end
            vectors++; if (data_result !== e.res) begin miscompares++; $display("FAIL signed_result[%0d] %h*%h got %h want %h", i, av[i], bv[i], data_result, e.res); end
            vectors++; if (data_exception !== e.exc) begin miscompares++; $display("FAIL signed_exc[%0d] %h*%h got %b want %b", i, av[i], bv[i], data_exception, e.exc); end
        end
    endtask

    task automatic test_abort;
        int   n, bc;
        bit   early;
        exp_t e;
        early = 1'b0;
        start_op(32'd100, 32'd100);
        repeat (7) begin
            @(negedge clk);
            if (data_resultRDY === 1'b1) early = 1'b1;
        end
        sb.delete();
        start_op(32'd2, 32'hFFFFFFFD);
        wait_rdy(1'b0, n, bc);
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL abort_early_rdy got %b want 0", early); end
        vectors++; if (n !== 17) begin miscompares++; $display("FAIL abort_latency got %0d want 17", n); end
        e = sb.pop_front();
        vectors++; if (data_result !== e.res || e.res !== 32'hFFFFFFFA) begin miscompares++; $display("FAIL abort_result got %h want %h", data_result, 32'hFFFFFFFA); end
        vectors++; if (data_exception !== 1'b0) begin miscompares++; $display("FAIL abort_exc got %b want 0", data_exception); end
    endtask

    task automatic test_async_reset;
        int   n, bc;
        bit   spurious;
        exp_t e;
        spurious = 1'b0;
        start_op(32'd123, 32'd456);
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        vectors++; if (data_result !== 32'd0) begin miscompares++; $display("FAIL areset_result got %h want 0", data_result); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy got %b want 0", busy); end
        vectors++; if (data_exception !== 1'b0) begin miscompares++; $display("FAIL areset_exc got %b want 0", data_exception); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (data_resultRDY === 1'b1 || busy === 1'b1) spurious = 1'b1;
        end
        vectors++; if (spurious !== 1'b0) begin miscompares++; $display("FAIL areset_no_rdy got %b want 0", spurious); end
        sb.delete();
        start_op(32'd1, 32'hFFFFFFFF);
        wait_rdy(1'b0, n, bc);
        e = sb.pop_front();
        vectors++; if (n !== 17) begin miscompares++; $display("FAIL areset_latency got %0d want 17", n); end
        vectors++; if (data_result !== e.res || e.res !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL areset_result2 got %h want %h", data_result, 32'hFFFFFFFF); end
    endtask

    task automatic test_operand_change;
        int   n, bc;
        exp_t e;
        start_op(32'd12345, -32'sd678);
        wait_rdy(1'b1, n, bc);
        e = sb.pop_front();
        vectors++; if (n !== 17) begin miscompares++; $display("FAIL opchg_latency got %0d want 17", n); end
        vectors++; if (data_result !== e.res) begin miscompares++; $display("FAIL opchg_result got %h want %h", data_result, e.res); end
        vectors++; if (data_exception !== e.exc) begin miscompares++; $display("FAIL opchg_exc got %b want %b", data_exception, e.exc); end
    endtask

    task automatic test_back_to_back;
        int   n, bc;
        exp_t e;
        start_op(32'hFFFF0000, 32'h00010001);
        wait_rdy(1'b0, n, bc);
        e = sb.pop_front();
        vectors++; if (data_result !== e.res) begin miscompares++; $display("FAIL b2b_first_result got %h want %h", data_result, e.res); end
        vectors++; if (data_exception !== e.exc) begin miscompares++; $display("FAIL b2b_first_exc got %b want %b", data_exception, e.exc); end
        // Start the next op in the ready cycle itself.
        start_op(32'h00000007, 32'hFFFFFFF3);
        wait_rdy(1'b0, n, bc);
        e = sb.pop_front();
        vectors++; if (n !== 17) begin miscompares++; $display("FAIL b2b_latency got %0d want 17", n); end
        vectors++; if (data_result !== e.res) begin miscompares++; $display("FAIL b2b_second_result got %h want %h", data_result, e.res); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_abort();
        test_async_reset();
        test_operand_change();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
